// File: rtl/vga_scanout_if.sv
// vga_scanout_if: synchronous framebuffer read port between the scanout and the pixel memory
interface vga_scanout_if #(
    parameter int COLOR_DEPTH = 9
);
    logic [18:0]            mem_addr;
    logic                   mem_rd;
    logic [COLOR_DEPTH-1:0] mem_data;
    modport master (output mem_addr, mem_rd, input mem_data);
    modport slave  (input mem_addr, mem_rd, output mem_data);
endinterface

// File: rtl/vga_scanout.sv
// vga_scanout: VGA timing generator that scans the framebuffer in raster order and drives RGB pins
module vga_scanout #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int COLOR_DEPTH = 9,
    parameter int PIX_DIV     = 2
) (
    input  logic          CLOCK_50,
    input  logic          Reset,
    vga_scanout_if.master mem,
    output logic [9:0]    VGA_X,
    output logic [8:0]    VGA_Y,
    output logic [23:0]   VGA_COLOR,
    output logic          plot,
    output logic          VGA_HS,
    output logic          VGA_VS,
    output logic          VGA_BLANK_N,
    output logic          VGA_CLK,
    output logic          VGA_SYNC
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int CW      = COLOR_DEPTH / 3;
    localparam int DW      = PIX_DIV > 1 ? $clog2(PIX_DIV) : 1;

    typedef enum logic [1:0] {H_ACT, H_FRONT, H_SYNC_ST, H_BACK} h_state_t;
    typedef enum logic [1:0] {V_ACT, V_FRONT, V_SYNC_ST, V_BACK} v_state_t;

    logic [DW-1:0] div, div_nx, d1, d2;
    logic [9:0]    h, h_nx, v, v_nx, h1, h2;
    logic [8:0]    v1, v2;
    logic [18:0]   row, row_nx;
    h_state_t      h_st, h_st_nx;
    v_state_t      v_st, v_st_nx;
    logic          pix_en, h_wrap, v_last, active, sync_nx;
    logic          a1, a2, hs1, hs2, vs1, vs2;

    // replicate the channel MSB-first until 8 bits are filled
    function automatic logic [7:0] expand(input logic [CW-1:0] c);
        return 8'({8{c}} >> (8 * CW - 8));
    endfunction

    always_comb begin
        pix_en  = div == DW'(PIX_DIV - 1);
        h_wrap  = pix_en && h == 10'(H_TOTAL - 1);
        v_last  = v == 10'(V_TOTAL - 1);
        div_nx  = pix_en ? '0 : div + DW'(1);
        h_nx    = !pix_en ? h : h_wrap ? '0 : h + 10'd1;
        v_nx    = !h_wrap ? v : v_last ? '0 : v + 10'd1;
        // running row base replaces y*H_ACTIVE so no multiplier is needed
        row_nx  = !h_wrap ? row : v_last ? '0 : row + 19'(H_ACTIVE);
        h_st_nx = h_nx == 10'd0 ? H_ACT :
                  h_nx == 10'(H_ACTIVE) ? H_FRONT :
                  h_nx == 10'(H_ACTIVE + H_FP) ? H_SYNC_ST :
                  h_nx == 10'(H_ACTIVE + H_FP + H_SYNC) ? H_BACK : h_st;
        v_st_nx = !h_wrap ? v_st :
                  v_nx == 10'd0 ? V_ACT :
                  v_nx == 10'(V_ACTIVE) ? V_FRONT :
                  v_nx == 10'(V_ACTIVE + V_FP) ? V_SYNC_ST :
                  v_nx == 10'(V_ACTIVE + V_FP + V_SYNC) ? V_BACK : v_st;
        active  = h_st == H_ACT && v_st == V_ACT;
        sync_nx = h_wrap && v_nx == 10'(V_ACTIVE);
    end

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            div      <= '0;
            h        <= '0;
            v        <= '0;
            row      <= '0;
            h_st     <= H_ACT;
            v_st     <= V_ACT;
            VGA_SYNC <= 1'b0;
        end else begin
            div      <= div_nx;
            h        <= h_nx;
            v        <= v_nx;
            row      <= row_nx;
            h_st     <= h_st_nx;
            v_st     <= v_st_nx;
            VGA_SYNC <= sync_nx;
        end
    end

    // three-stage pipeline: address issue, memory access, pin capture
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            mem.mem_addr <= '0;
            mem.mem_rd   <= 1'b0;
            {h1, v1, a1, hs1, vs1, d1} <= '0;
            {h2, v2, a2, hs2, vs2, d2} <= '0;
            VGA_X        <= '0;
            VGA_Y        <= '0;
            VGA_COLOR    <= '0;
            plot         <= 1'b0;
            VGA_BLANK_N  <= 1'b0;
            VGA_HS       <= 1'b1;
            VGA_VS       <= 1'b1;
            VGA_CLK      <= 1'b0;
        end else begin
            mem.mem_rd   <= active;
            if (active) mem.mem_addr <= row + 19'(h);
            {h1, v1, a1, hs1, vs1, d1} <= {h, v[8:0], active, h_st == H_SYNC_ST, v_st == V_SYNC_ST, div};
            {h2, v2, a2, hs2, vs2, d2} <= {h1, v1, a1, hs1, vs1, d1};
            VGA_X        <= h2;
            VGA_Y        <= v2;
            VGA_COLOR    <= a2 ? {expand(mem.mem_data[3*CW-1 -: CW]), expand(mem.mem_data[2*CW-1 -: CW]),
                                  expand(mem.mem_data[CW-1:0])} : '0;
            plot         <= a2;
            VGA_BLANK_N  <= a2;
            VGA_HS       <= !hs2;
            VGA_VS       <= !vs2;
            VGA_CLK      <= d2 >= DW'(PIX_DIV / 2);
        end
    end
endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: scaled-timing instance under random resets plus a full 640x480 instance, both against an arithmetic model
module tb_vga_scanout;
    typedef struct packed {int ha, hf, hs, hb, va, vf, vs, vb, d;} cfg_t;
    localparam cfg_t CS = '{ha: 16, hf: 2, hs: 4, hb: 3, va: 6, vf: 1, vs: 2, vb: 2, d: 4};
    localparam cfg_t CF = '{ha: 640, hf: 16, hs: 96, hb: 48, va: 480, vf: 10, vs: 2, vb: 33, d: 2};

    logic clk = 1'b0, rst_s = 1'b1, rst_f = 1'b1, mode_s = 1'b0;
    int seed_s, seed_f, checks = 0, errors = 0, n_s = -1, n_f = -1, last_s = 0, last_f = 0;
    logic [9:0] x_s, x_f;
    logic [8:0] y_s, y_f;
    logic [23:0] col_s, col_f;
    logic plot_s, hs_s, vs_s, blank_s, vclk_s, sync_s;
    logic plot_f, hs_f, vs_f, blank_f, vclk_f, sync_f;

    vga_scanout_if #(.COLOR_DEPTH(9)) bus_s ();
    vga_scanout_if #(.COLOR_DEPTH(9)) bus_f ();

    vga_scanout #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3), .V_ACTIVE(6), .V_FP(1), .V_SYNC(2),
                  .V_BP(2), .COLOR_DEPTH(9), .PIX_DIV(4)) u_s (
        .CLOCK_50(clk), .Reset(rst_s), .mem(bus_s), .VGA_X(x_s), .VGA_Y(y_s), .VGA_COLOR(col_s),
        .plot(plot_s), .VGA_HS(hs_s), .VGA_VS(vs_s), .VGA_BLANK_N(blank_s), .VGA_CLK(vclk_s), .VGA_SYNC(sync_s));

    vga_scanout u_f (
        .CLOCK_50(clk), .Reset(rst_f), .mem(bus_f), .VGA_X(x_f), .VGA_Y(y_f), .VGA_COLOR(col_f),
        .plot(plot_f), .VGA_HS(hs_f), .VGA_VS(vs_f), .VGA_BLANK_N(blank_f), .VGA_CLK(vclk_f), .VGA_SYNC(sync_f));

    always #5 clk = ~clk;

    function automatic logic [8:0] word(input int a, input bit m, input int seed);
        if (a == 213) return 9'h1C0;
        return m ? 9'h1FF : 9'((a * 37 + seed) ^ (a >> 4));
    endfunction

    function automatic logic [23:0] rgb(input logic [8:0] w);
        logic [23:0] o = '0;
        for (int ch = 0; ch < 3; ch++)
            for (int i = 0; i < 8; i++) o[23 - 8 * ch - i] = w[8 - 3 * ch - (i % 3)];
        return o;
    endfunction

    // where the counters stand k cycles after reset release
    function automatic void loc(input cfg_t c, input int k, output int h, output int v, output int dv, output bit act);
        int ht = c.ha + c.hf + c.hs + c.hb;
        int vt = c.va + c.vf + c.vs + c.vb;
        dv  = k % c.d;
        h   = (k / c.d) % ht;
        v   = (k / c.d / ht) % vt;
        act = h < c.ha && v < c.va;
    endfunction

    function automatic int next_last(input cfg_t c, input int n, input int last);
        int h, v, dv;
        bit act;
        if (n == 0) return 0;
        loc(c, n - 1, h, v, dv, act);
        return act ? v * c.ha + h : last;
    endfunction

    function automatic logic [68:0] model(input cfg_t c, input int n, input int last, input bit m, input int seed);
        int h, v, dv;
        bit act, sync, rd = 0, plot = 0, hs = 1, vs = 1, vclk = 0;
        logic [9:0] x = '0;
        logic [8:0] y = '0;
        logic [23:0] col = '0;
        loc(c, n, h, v, dv, act);
        sync = dv == 0 && h == 0 && v == c.va;
        if (n >= 1) begin
            loc(c, n - 1, h, v, dv, act);
            rd = act;
        end
        if (n >= 3) begin
            loc(c, n - 3, h, v, dv, act);
            x    = 10'(h);
            y    = 9'(v);
            plot = act;
            hs   = !(h >= c.ha + c.hf && h < c.ha + c.hf + c.hs);
            vs   = !(v >= c.va + c.vf && v < c.va + c.vf + c.vs);
            vclk = dv >= c.d / 2;
            col  = act ? rgb(word(v * c.ha + h, m, seed)) : '0;
        end
        return {x, y, col, plot, hs, vs, plot, vclk, sync, rd, 19'(last)};
    endfunction

    task automatic chk(input string nm, input int n, input logic [68:0] got, input logic [68:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h want %h", nm, n, got, want);
        end
    endtask

    always @(posedge clk) begin
        n_s <= rst_s ? 0 : n_s < 0 ? -1 : n_s + 1;
        n_f <= rst_f ? 0 : n_f < 0 ? -1 : n_f + 1;
        if (bus_s.mem_rd) bus_s.mem_data <= word(int'(bus_s.mem_addr), mode_s, seed_s);
        if (bus_f.mem_rd) bus_f.mem_data <= word(int'(bus_f.mem_addr), 1'b0, seed_f);
    end

    always @(negedge clk) begin
        if (n_s >= 0) begin
            last_s = next_last(CS, n_s, last_s);
            chk("small_pins", n_s, {x_s, y_s, col_s, plot_s, hs_s, vs_s, blank_s, vclk_s, sync_s, bus_s.mem_rd,
                bus_s.mem_addr}, model(CS, n_s, last_s, mode_s, seed_s));
            if (n_s == 1) chk("small_after_reset", n_s, 69'({hs_s, vs_s, blank_s, plot_s, col_s, sync_s}),
                69'({1'b1, 1'b1, 1'b0, 1'b0, 24'h0, 1'b0}));
            if (n_s == 599) chk("small_sync_before", n_s, 69'(sync_s), 69'(0));
            if (n_s == 600) chk("small_sync_at_v6", n_s, 69'(sync_s), 69'(1));
            if (n_s == 3 && mode_s) chk("small_white", n_s, 69'(col_s), 69'(24'hFFFFFF));
        end
        if (n_f >= 0) begin
            last_f = next_last(CF, n_f, last_f);
            chk("full_pins", n_f, {x_f, y_f, col_f, plot_f, hs_f, vs_f, blank_f, vclk_f, sync_f, bus_f.mem_rd,
                bus_f.mem_addr}, model(CF, n_f, last_f, 1'b0, seed_f));
            if (n_f == 0) chk("full_reset", n_f, 69'({hs_f, vs_f, blank_f, plot_f, col_f, sync_f, vclk_f}),
                69'({1'b1, 1'b1, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0}));
            if (n_f == 427) chk("full_addr_213", n_f, 69'({bus_f.mem_rd, bus_f.mem_addr}), 69'({1'b1, 19'd213}));
            if (n_f == 429) chk("full_pix_213", n_f, 69'({x_f, y_f, col_f, plot_f}),
                69'({10'd213, 9'd0, 24'hFF0000, 1'b1}));
            if (n_f == 1282) chk("full_blank_last", n_f, 69'({blank_f, x_f}), 69'({1'b1, 10'd639}));
            if (n_f == 1283) chk("full_blank_start", n_f, 69'({blank_f, x_f}), 69'({1'b0, 10'd640}));
            if (n_f == 1314) chk("full_hs_before", n_f, 69'({hs_f, x_f}), 69'({1'b1, 10'd655}));
            if (n_f == 1315) chk("full_hs_fall", n_f, 69'({hs_f, x_f}), 69'({1'b0, 10'd656}));
            if (n_f == 1613) chk("full_line1", n_f, 69'({y_f, x_f, plot_f}), 69'({9'd1, 10'd5, 1'b1}));
        end
    end

    task automatic run(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic pulse(input int len, input bit m);
        @(negedge clk) rst_s = 1'b1;
        @(negedge clk) begin
            mode_s = m;
            seed_s = int'($urandom);
        end
        repeat (len - 1) @(negedge clk);
        rst_s = 1'b0;
    endtask

    initial begin
        seed_s = int'($urandom);
        seed_f = int'($urandom);
        run(3);
        rst_s = 1'b0;
        rst_f = 1'b0;
        run(2300);
        pulse(3, 1'b1);
        run(1200);
        pulse(3, 1'b0);
        run(1300);
        repeat (5) begin
            pulse(int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)));
            run(int'($urandom_range(20, 1400)));
        end
        run(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
